// File: rtl/led_seq_pkg.sv
// led_seq_pkg: shared constants for the LED pattern sequencer.
// Register map, CTRL/STATUS bit positions, modes and FSM states.
package led_seq_pkg;

  localparam logic [1:0] ADDR_CTRL    = 2'd0;
  localparam logic [1:0] ADDR_PERIOD  = 2'd1;
  localparam logic [1:0] ADDR_PATTERN = 2'd2;
  localparam logic [1:0] ADDR_STATUS  = 2'd3;

  localparam int CTRL_EN_BIT   = 0;
  localparam int CTRL_MODE_LSB = 1;
  localparam int CTRL_MODE_MSB = 2;

  localparam int STAT_RUN_BIT = 0;
  localparam int STAT_DIR_BIT = 1;
  localparam int STAT_CUR_LSB = 8;

  typedef enum logic [1:0] {
    MODE_STATIC = 2'd0,
    MODE_ROTATE = 2'd1,
    MODE_BOUNCE = 2'd2,
    MODE_COUNT  = 2'd3
  } mode_e;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;

endpackage

// File: rtl/led_pattern_next.sv
// led_pattern_next: next LED pattern and bounce direction
// for the current mode; purely combinational.
module led_pattern_next
  import led_seq_pkg::*;
#(
  parameter int LED_W = 8
) (
  input  logic [LED_W-1:0] cur_i,
  input  logic             dir_i,
  input  logic [1:0]       mode_i,
  input  logic [LED_W-1:0] pattern_i,
  output logic [LED_W-1:0] next_o,
  output logic             dir_o
);

  logic             go_right;
  logic [LED_W-1:0] shl;
  logic [LED_W-1:0] shr;

  // Bounce turns around early if a bit already sits at the edge
  always_comb begin
    go_right = dir_i ? ~cur_i[0] : cur_i[LED_W-1];
    shl      = cur_i << 1;
    shr      = cur_i >> 1;
  end

  // Mode-dependent step
  always_comb begin
    next_o = cur_i;
    dir_o  = dir_i;
    unique case (mode_e'(mode_i))
      MODE_STATIC: next_o = pattern_i;
      MODE_ROTATE: next_o = {cur_i[LED_W-2:0], cur_i[LED_W-1]};
      MODE_BOUNCE: begin
        if (cur_i == '0) begin
          next_o = LED_W'(1);
          dir_o  = 1'b0;
        end else if (go_right) begin
          next_o = shr;
          dir_o  = ~shr[0];
        end else begin
          next_o = shl;
          dir_o  = shl[LED_W-1];
        end
      end
      MODE_COUNT:  next_o = cur_i + LED_W'(1);
      default:     next_o = cur_i;
    endcase
  end

endmodule

// File: rtl/led_pattern_sequencer.sv
// led_pattern_sequencer: config slave plus timed Avalon-MM
// master that plays LED patterns into an 8-bit PIO.
module led_pattern_sequencer
  import led_seq_pkg::*;
#(
  parameter int                LED_W          = 8,
  parameter int                PERIOD_W       = 32,
  parameter logic [PERIOD_W-1:0] DEFAULT_PERIOD = PERIOD_W'(50_000_000)
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  s_address,
  input  logic        s_chipselect,
  input  logic        s_write_n,
  input  logic [31:0] s_writedata,
  output logic [31:0] s_readdata,
  output logic        m_chipselect,
  output logic        m_write_n,
  output logic [1:0]  m_address,
  output logic [31:0] m_writedata
);

  logic                en_q,      en_d;
  logic [1:0]          mode_q,    mode_d;
  logic [PERIOD_W-1:0] period_q,  period_d;
  logic [LED_W-1:0]    pattern_q, pattern_d;
  logic [LED_W-1:0]    cur_q,     cur_d;
  logic                dir_q,     dir_d;
  logic [PERIOD_W-1:0] timer_q,   timer_d;
  logic [1:0]          state_q,   state_d;

  logic                cfg_wr;
  logic                wr_ctrl;
  logic                wr_period;
  logic                wr_pattern;
  logic                new_en;
  logic [PERIOD_W-1:0] p_eff;
  logic                tc;
  logic [LED_W-1:0]    nxt;
  logic                nxt_dir;
  logic                m_wr;
  logic [LED_W-1:0]    wr_pat;
  logic [31:0]         wr_data;
  logic [31:0]         rd;
  logic                running;

  led_pattern_next #(
    .LED_W(LED_W)
  ) u_next (
    .cur_i    (cur_q),
    .dir_i    (dir_q),
    .mode_i   (mode_q),
    .pattern_i(pattern_q),
    .next_o   (nxt),
    .dir_o    (nxt_dir)
  );

  // Config write decode and step timing
  always_comb begin
    cfg_wr     = s_chipselect & ~s_write_n;
    wr_ctrl    = cfg_wr & (s_address == ADDR_CTRL);
    wr_period  = cfg_wr & (s_address == ADDR_PERIOD);
    wr_pattern = cfg_wr & (s_address == ADDR_PATTERN);
    new_en     = s_writedata[CTRL_EN_BIT];
    p_eff      = (period_q < PERIOD_W'(2)) ? PERIOD_W'(2) : period_q;
    tc         = (timer_q == p_eff - PERIOD_W'(1));
    running    = (state_q != ST_IDLE);
  end

  // Register updates, FSM and master write generation
  always_comb begin
    en_d      = en_q;
    mode_d    = mode_q;
    period_d  = period_q;
    pattern_d = pattern_q;
    cur_d     = cur_q;
    dir_d     = dir_q;
    timer_d   = timer_q;
    state_d   = state_q;
    m_wr      = 1'b0;
    wr_pat    = '0;
    if (wr_ctrl) begin
      en_d   = new_en;
      mode_d = s_writedata[CTRL_MODE_MSB:CTRL_MODE_LSB];
    end
    if (wr_period)  period_d  = s_writedata[PERIOD_W-1:0];
    if (wr_pattern) pattern_d = s_writedata[LED_W-1:0];
    unique case (state_q)
      ST_IDLE: begin
        if (wr_ctrl && new_en && !en_q) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        m_wr    = 1'b1;
        wr_pat  = pattern_q;
        cur_d   = pattern_q;
        dir_d   = 1'b0;
        timer_d = '0;
        state_d = ST_RUN;
        if (wr_ctrl && !new_en) state_d = ST_IDLE;
        else if (wr_pattern)    state_d = ST_LOAD;
      end
      ST_RUN: begin
        timer_d = tc ? '0 : timer_q + PERIOD_W'(1);
        // PATTERN/PERIOD writes restart timing, so the step is dropped
        if (tc && !wr_pattern && !wr_period) begin
          m_wr   = 1'b1;
          wr_pat = nxt;
          cur_d  = nxt;
          dir_d  = nxt_dir;
        end
        if (wr_ctrl && !new_en) state_d = ST_IDLE;
        else if (wr_pattern)    state_d = ST_LOAD;
        else if (wr_period)     timer_d = '0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Master port and write data packing
  always_comb begin
    wr_data              = '0;
    wr_data[LED_W-1:0]   = wr_pat;
    m_chipselect         = m_wr;
    m_write_n            = ~m_wr;
    m_address            = 2'b00;
    m_writedata          = wr_data;
  end

  // Zero-wait config readback
  always_comb begin
    rd = '0;
    unique case (s_address)
      ADDR_CTRL: begin
        rd[CTRL_EN_BIT]                 = en_q;
        rd[CTRL_MODE_MSB:CTRL_MODE_LSB] = mode_q;
      end
      ADDR_PERIOD:  rd[PERIOD_W-1:0] = period_q;
      ADDR_PATTERN: rd[LED_W-1:0]    = pattern_q;
      ADDR_STATUS: begin
        rd[STAT_RUN_BIT]             = running;
        rd[STAT_DIR_BIT]             = dir_q;
        rd[STAT_CUR_LSB +: LED_W]    = cur_q;
      end
      default: rd = '0;
    endcase
    s_readdata = rd;
  end

  // State registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      en_q      <= 1'b0;
      mode_q    <= 2'b00;
      period_q  <= DEFAULT_PERIOD;
      pattern_q <= LED_W'(1);
      cur_q     <= '0;
      dir_q     <= 1'b0;
      timer_q   <= '0;
      state_q   <= ST_IDLE;
    end else begin
      en_q      <= en_d;
      mode_q    <= mode_d;
      period_q  <= period_d;
      pattern_q <= pattern_d;
      cur_q     <= cur_d;
      dir_q     <= dir_d;
      timer_q   <= timer_d;
      state_q   <= state_d;
    end
  end

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// tb_led_pattern_sequencer: directed bench for the LED
// pattern sequencer with hand-computed write sequences.
module tb_led_pattern_sequencer;
  import led_seq_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  s_address = 2'b00;
  logic        s_chipselect = 1'b0;
  logic        s_write_n = 1'b1;
  logic [31:0] s_writedata = '0;
  logic [31:0] s_readdata;
  logic        m_chipselect;
  logic        m_write_n;
  logic [1:0]  m_address;
  logic [31:0] m_writedata;

  led_pattern_sequencer dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .s_address   (s_address),
    .s_chipselect(s_chipselect),
    .s_write_n   (s_write_n),
    .s_writedata (s_writedata),
    .s_readdata  (s_readdata),
    .m_chipselect(m_chipselect),
    .m_write_n   (m_write_n),
    .m_address   (m_address),
    .m_writedata (m_writedata)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  int          q_cyc[$];
  logic [31:0] q_dat[$];
  logic [1:0]  q_adr[$];

  logic [31:0] e_rot[4] = '{32'h81, 32'h03, 32'h06, 32'h0C};
  logic [31:0] e_bnc[4] = '{32'h40, 32'h80, 32'h40, 32'h20};
  logic [31:0] e_cnt[4] = '{32'hFE, 32'hFF, 32'h00, 32'h01};

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (reset_n && m_chipselect && !m_write_n) begin
      q_cyc.push_back(cyc);
      q_dat.push_back(m_writedata);
      q_adr.push_back(m_address);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic cfg_wr(input logic [1:0] a, input logic [31:0] d);
    s_address    = a;
    s_writedata  = d;
    s_chipselect = 1'b1;
    s_write_n    = 1'b0;
    tick(1);
    s_chipselect = 1'b0;
    s_write_n    = 1'b1;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    s_address = a;
    #1;
    d = s_readdata;
  endtask

  task automatic wait_wr(input int n, input int budget, input string tag);
    int k = 0;
    while (q_dat.size() < n && k < budget) begin
      tick(1);
      k++;
    end
    chk(tag, 32'(q_dat.size() >= n), 32'd1);
  endtask

  function automatic logic [31:0] qd(input int i);
    return (i < q_dat.size()) ? q_dat[i] : 32'hDEADBEEF;
  endfunction

  function automatic int qc(input int i);
    return (i < q_cyc.size()) ? q_cyc[i] : -1000;
  endfunction

  function automatic logic [31:0] qa(input int i);
    return (i < q_adr.size()) ? 32'(q_adr[i]) : 32'hF;
  endfunction

  task automatic clr();
    q_cyc.delete();
    q_dat.delete();
    q_adr.delete();
  endtask

  task automatic stop_run();
    cfg_wr(ADDR_CTRL, 32'd0);
    tick(2);
    clr();
  endtask

  initial begin
    logic [31:0] d;
    int L;
    int k;

    tick(3);
    reset_n = 1'b1;
    tick(1);
    rd(ADDR_STATUS, d);  chk("rst_status", d, 32'd0);
    rd(ADDR_PERIOD, d);  chk("rst_period", d, 32'd50000000);
    rd(ADDR_PATTERN, d); chk("rst_pattern", d, 32'h01);
    rd(ADDR_CTRL, d);    chk("rst_ctrl", d, 32'd0);
    chk("rst_wn", 32'(m_write_n), 32'd1);
    tick(1000);
    chk("rst_nwr", 32'(q_dat.size()), 32'd0);
    clr();

    cfg_wr(ADDR_PERIOD, 32'd4);
    cfg_wr(ADDR_PATTERN, 32'h81);
    cfg_wr(ADDR_CTRL, 32'b011);
    wait_wr(4, 100, "rot_n");
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rot_d%0d", i), qd(i), e_rot[i]);
      chk($sformatf("rot_a%0d", i), qa(i), 32'd0);
    end
    for (int i = 1; i < 4; i++)
      chk($sformatf("rot_gap%0d", i), 32'(qc(i) - qc(i-1)), 32'd4);
    stop_run();

    cfg_wr(ADDR_PERIOD, 32'd2);
    cfg_wr(ADDR_PATTERN, 32'h40);
    cfg_wr(ADDR_CTRL, 32'b101);
    wait_wr(2, 50, "bnc_n2");
    rd(ADDR_STATUS, d);
    chk("bnc_dir", {31'b0, d[1]}, 32'd1);
    wait_wr(4, 50, "bnc_n");
    for (int i = 0; i < 4; i++)
      chk($sformatf("bnc_d%0d", i), qd(i), e_bnc[i]);
    for (int i = 1; i < 4; i++)
      chk($sformatf("bnc_gap%0d", i), 32'(qc(i) - qc(i-1)), 32'd2);
    stop_run();

    cfg_wr(ADDR_PERIOD, 32'd0);
    cfg_wr(ADDR_PATTERN, 32'hFE);
    cfg_wr(ADDR_CTRL, 32'b111);
    wait_wr(4, 50, "cnt_n");
    for (int i = 0; i < 4; i++)
      chk($sformatf("cnt_d%0d", i), qd(i), e_cnt[i]);
    for (int i = 1; i < 4; i++)
      chk($sformatf("cnt_gap%0d", i), 32'(qc(i) - qc(i-1)), 32'd2);
    stop_run();

    cfg_wr(ADDR_PERIOD, 32'd5);
    cfg_wr(ADDR_PATTERN, 32'h11);
    cfg_wr(ADDR_CTRL, 32'b001);
    wait_wr(1, 50, "col_n1");
    L = qc(0);
    k = 0;
    while (cyc < L + 10 && k < 50) begin
      tick(1);
      k++;
    end
    chk("col_sync", 32'(cyc - L), 32'd10);
    cfg_wr(ADDR_PATTERN, 32'h5A);
    wait_wr(4, 60, "col_n");
    chk("col_d0", qd(0), 32'h11);
    chk("col_d1", qd(1), 32'h11);
    chk("col_c1", 32'(qc(1) - L), 32'd5);
    chk("col_d2", qd(2), 32'h5A);
    chk("col_c2", 32'(qc(2) - L), 32'd11);
    chk("col_d3", qd(3), 32'h5A);
    chk("col_c3", 32'(qc(3) - L), 32'd16);
    stop_run();

    cfg_wr(ADDR_PERIOD, 32'd3);
    cfg_wr(ADDR_CTRL, 32'b111);
    wait_wr(2, 50, "dis_n");
    cfg_wr(ADDR_CTRL, 32'b110);
    tick(1);
    clr();
    tick(30);
    chk("dis_nwr", 32'(q_dat.size()), 32'd0);
    rd(ADDR_STATUS, d);
    chk("dis_run", {31'b0, d[0]}, 32'd0);

    cfg_wr(ADDR_CTRL, 32'b111);
    wait_wr(1, 50, "ar_n");
    s_address = ADDR_STATUS;
    #1;
    chk("ar_run", {31'b0, s_readdata[0]}, 32'd1);
    k = 0;
    while (m_write_n && k < 20) begin
      tick(1);
      k++;
    end
    chk("ar_found", 32'(m_write_n), 32'd0);
    #1;
    reset_n = 1'b0;
    #1;
    chk("ar_wn", 32'(m_write_n), 32'd1);
    chk("ar_cs", 32'(m_chipselect), 32'd0);
    chk("ar_wd", m_writedata, 32'd0);
    chk("ar_rd", s_readdata, 32'd0);
    tick(2);
    reset_n = 1'b1;
    tick(1);
    rd(ADDR_PERIOD, d);
    chk("ar_period", d, 32'd50000000);
    rd(ADDR_CTRL, d);
    chk("ar_ctrl", d, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/led_pattern_sequencer.md
Name: led_pattern_sequencer

Overview:
- Autonomous controller for the 8-bit LED PIO slave (Avalon-MM, 2-bit address, zero-wait write, register 0 = LED data).
- Exposes a small Avalon-MM config slave to the HPS.
- Its Avalon-MM master port issues timed single-cycle writes to the PIO to play static, rotate, bounce or count patterns without CPU involvement.

Parameters:
- LED_W, 8, LED/pattern width; PIO data register width.
- PERIOD_W, 32, width of the step-period register and timer.
- DEFAULT_PERIOD, 50000000, reset value of PERIOD (1 s at 50 MHz).

Ports:
- clk  in  1  system clock
- reset_n  in  1  reset
- s_address  in  2  config register select
- s_chipselect  in  1  config slave select
- s_write_n  in  1  config write strobe, active-low
- s_writedata  in  32  config write data
- s_readdata  out  32  config read data, combinational, zero wait
- m_chipselect  out  1  PIO select
- m_write_n  out  1  PIO write strobe, active-low
- m_address  out  2  PIO address, constant 0
- m_writedata  out  32  PIO write data, {zeros, pattern}

Behaviour:
- Clock/reset: reset reset_n, asynchronous, active-low; clock clk.
- Registers:
  - 0 CTRL: [0] enable, [2:1] mode (0 static, 1 rotate-left, 2 bounce, 3 count).
  - 1 PERIOD: cycles per step; values 0 and 1 are treated as 2.
  - 2 PATTERN: static value and seed, [LED_W-1:0].
  - 3 STATUS, read-only: [0] running, [1] direction (1 = right), [15:8] cur.
  - Writes to register 3 are ignored. Unused bits read 0.
- Reset values:
  - CTRL=0, PERIOD=DEFAULT_PERIOD, PATTERN=0x01, cur=0, dir=0, timer=0, state=IDLE.
  - m_chipselect=0, m_write_n=1, m_writedata=0, m_address=0.
  - s_readdata reflects these values.
- Master writes:
  - Each write is exactly one cycle with m_chipselect=1, m_write_n=0, m_writedata={0, cur_next}.
  - No wait-request: the PIO accepts every write in 1 cycle.
- FSM states:
  - IDLE: no writes.
  - IDLE→LOAD on a CTRL write that sets enable 0→1.
  - LOAD (1 cycle): cur<=PATTERN, dir<=0, timer<=0, write cur issued this cycle; →RUN.
  - RUN: timer counts 0..P-1 (P = effective period). At timer==P-1: timer<=0, cur<=next(cur), write next(cur) in the same cycle.
  - Write spacing is exactly P cycles. First step write occurs P cycles after the LOAD write.
- next(cur) by mode:
  - static: PATTERN.
  - rotate: {cur[LED_W-2:0], cur[LED_W-1]}.
  - bounce: shift toward current dir; dir flips when the shifted bit reaches bit LED_W-1 (left) or bit 0 (right). If cur==0, load 0x01, dir=0.
  - count: cur+1, modulo 2^LED_W.
- Mode change while RUN: takes effect at the next step; cur and timer are kept.
- PATTERN write while RUN: behaves as LOAD (reload, timer restart, immediate write).
- PERIOD write while RUN: timer<=0.
- Simultaneous config write and terminal count: the config-write action wins; the step is dropped (no double write).
- enable 1→0: →IDLE next cycle, no further writes; LEDs hold the last written value. A write in the same cycle completes normally.
- Async reset mid-RUN: outputs return to reset values immediately; the PIO resets independently.

Decomposition:
- Shared package led_seq_pkg:
  - register address constants (ADDR_CTRL..ADDR_STATUS)
  - mode enum (MODE_STATIC, MODE_ROTATE, MODE_BOUNCE, MODE_COUNT)
  - FSM state enum
  - CTRL bit positions
- One sub-module: led_pattern_next, combinational. Takes cur, dir, mode, PATTERN; returns next pattern and next dir.
- Timer, registers and FSM stay in the top level.

Test Plan:
- Reset, no config access → no master write for 1000 cycles; STATUS reads 0; PERIOD reads 50000000.
- PERIOD=4, PATTERN=0x81, CTRL=0b011 (rotate, enable) → writes 0x81, 0x03, 0x06, 0x0C, each exactly 4 cycles apart; m_address=0 on every write.
- PERIOD=2, PATTERN=0x40, bounce → writes 0x40, 0x80, 0x40, 0x20; STATUS[1]=1 after the 0x80 step.
- PERIOD=0, count, PATTERN=0xFE → writes 0xFE, 0xFF, 0x00, 0x01, spaced 2 cycles.
- PATTERN write in the same cycle as terminal count (PERIOD=5) → exactly one write, carrying the new PATTERN; the next step follows 5 cycles later.
- Clear enable mid-RUN → no writes after IDLE; then assert reset_n=0 asynchronously mid-RUN → m_write_n=1 and s_readdata=0 without waiting for a clock edge.
